pwm_capture: RTL and testbench

- Receive side of the team's 8-bit PWM DAC link: recovers the WIDTH-bit code from a single-wire PWM stream whose frame is fixed at 2**WIDTH clk cycles and whose high time is `code` cycles per frame.
- Sits on a board or loopback input and feeds the recovered code to downstream logic.
- Used as a self-test readback path for the PWM DAC.

---
 rtl/pwm_capture.sv | 191 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: receive side of the PWM DAC link. Recovers a WIDTH-bit code
// from a single-wire PWM stream whose frame is 2**WIDTH clk cycles long and
// whose high time is `code` cycles per frame.
//
// Optional build macro PWM_CAPTURE_MATCH_EN: a good measurement window is only
// reported when its high count equals the previous good window's high count.
// This hides the single intermediate value produced when the transmitter
// changes code mid-frame.
//
// Handshake: `valid` is a one-cycle pulse qualifying `code`. There is no
// ready; the consumer must take `code` in the cycle `valid` is high. `err`
// is a one-cycle pulse per malformed frame and is never high with `valid`.
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2    // at least 2 flops on the async input
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] code,
    output logic             valid,
    output logic             locked,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int PERIOD = 2 ** WIDTH;
    localparam logic [WIDTH:0] PERIOD_C = PERIOD[WIDTH:0];
    localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};

    // HUNT: no window open yet. MEAS: measuring rise-to-rise windows.
    // FLAT: line steadily low, reporting code 0 once per frame.
    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_MEAS = 2'd1,
        S_FLAT = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d_q;
    logic [WIDTH:0]         per_cnt_q;
    logic [WIDTH:0]         hi_cnt_q;
    logic [WIDTH-1:0]       code_q;
    logic                   valid_q;
    logic                   locked_q;
    logic                   err_q;
`ifdef PWM_CAPTURE_MATCH_EN
    logic [WIDTH-1:0]       match_q;     // high count of the previous good window
`endif

    logic           pwm_s;
    logic           rise;
    logic [WIDTH:0] per_inc;
    logic [WIDTH:0] hi_inc;

    assign pwm_s   = sync_q[SYNC_STAGES-1];
    assign rise    = pwm_s & ~pwm_d_q;
    assign per_inc = per_cnt_q + CNT_ONE;
    assign hi_inc  = hi_cnt_q + {{WIDTH{1'b0}}, pwm_s};

    // Synchronise the asynchronous input and keep one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_d_q <= pwm_s;
        end
    end

    // Window measurement FSM with registered code/valid/locked/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HUNT;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef PWM_CAPTURE_MATCH_EN
            match_q   <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_HUNT: begin
                    if (rise) begin
                        state_q   <= S_MEAS;
                        per_cnt_q <= CNT_ONE;
                        hi_cnt_q  <= CNT_ONE;
                    end else if (per_cnt_q == PERIOD_C) begin
                        if (!pwm_s) begin
                            // A full frame with no rise and a low line: code 0.
                            state_q   <= S_FLAT;
                            code_q    <= '0;
                            valid_q   <= 1'b1;
                            locked_q  <= 1'b1;
                            per_cnt_q <= CNT_ONE;
                        end else begin
                            // Stuck high is never a valid code.
                            err_q     <= 1'b1;
                            per_cnt_q <= '0;
`ifdef PWM_CAPTURE_MATCH_EN
                            match_q   <= '0;
`endif
                        end
                    end else begin
                        per_cnt_q <= per_inc;
                    end
                end

                S_MEAS: begin
                    if (rise) begin
                        // The previous window closes here; judge it by its length.
                        per_cnt_q <= CNT_ONE;
                        hi_cnt_q  <= CNT_ONE;
                        if (per_cnt_q == PERIOD_C) begin
                            locked_q <= 1'b1;
`ifdef PWM_CAPTURE_MATCH_EN
                            if (hi_cnt_q[WIDTH-1:0] == match_q) begin
                                code_q  <= hi_cnt_q[WIDTH-1:0];
                                valid_q <= 1'b1;
                            end
                            match_q <= hi_cnt_q[WIDTH-1:0];
`else
                            code_q  <= hi_cnt_q[WIDTH-1:0];
                            valid_q <= 1'b1;
`endif
                        end else begin
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
`ifdef PWM_CAPTURE_MATCH_EN
                            match_q  <= '0;
`endif
                        end
                    end else if (per_cnt_q != PERIOD_C) begin
                        per_cnt_q <= per_inc;
                        hi_cnt_q  <= hi_inc;
                    end else if (!pwm_s) begin
                        // Window overran while low: transmitter went to code 0.
                        state_q   <= S_FLAT;
                        code_q    <= '0;
                        valid_q   <= 1'b1;
                        locked_q  <= 1'b1;
                        per_cnt_q <= CNT_ONE;
                    end else begin
                        // Window overran while high: line stuck or too slow.
                        state_q   <= S_HUNT;
                        err_q     <= 1'b1;
                        locked_q  <= 1'b0;
                        per_cnt_q <= '0;
`ifdef PWM_CAPTURE_MATCH_EN
                        match_q   <= '0;
`endif
                    end
                end

                S_FLAT: begin
                    if (rise) begin
                        // locked holds until the first measured window is judged.
                        state_q   <= S_MEAS;
                        per_cnt_q <= CNT_ONE;
                        hi_cnt_q  <= CNT_ONE;
                    end else if (per_cnt_q == PERIOD_C) begin
                        code_q    <= '0;
                        valid_q   <= 1'b1;
                        per_cnt_q <= CNT_ONE;
                    end else begin
                        per_cnt_q <= per_inc;
                    end
                end

                default: begin
                    state_q   <= S_HUNT;
                    per_cnt_q <= '0;
                end
            endcase
        end
    end

    assign code      = code_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives frame lists (high, low cycle pairs) into pwm_capture
// and compares the stream of valid/err events against a frame-level model.
module tb_pwm_capture;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int PERIOD      = 2 ** WIDTH;

    // ---------------- clock / reset ----------------
    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             pwm_in = 1'b0;
    logic [WIDTH-1:0] code;
    logic             valid;
    logic             locked;
    logic             err;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .code      (code),
        .valid     (valid),
        .locked    (locked),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- event monitor ----------------
    // Event encoding: bit WIDTH set = err pulse, else valid with code in low bits.
    logic [WIDTH:0] obs_q[$];
    int             obs_cyc[$];
    logic [WIDTH:0] exp_q[$];

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            obs_q.push_back({1'b0, code});
            obs_cyc.push_back(cyc);
        end
        if (err === 1'b1) begin
            obs_q.push_back({1'b1, {WIDTH{1'b0}}});
            obs_cyc.push_back(cyc);
        end
    end

    // ---------------- checks ----------------
    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
            $error("%s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
            $error("%s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // ---------------- driver ----------------
    int fr_hi[$];
    int fr_lo[$];

    task automatic add_frames(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            fr_hi.push_back(h);
            fr_lo.push_back(l);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 pwm_in = v;
        end
    endtask

    // Reset, then drive `pre` low cycles, the frame list, and `trail` low cycles.
    // Model: every rise closes the previous frame; a frame of exactly PERIOD
    // cycles is a good window reporting its high count, anything shorter is an
    // error. After the last rise (or after reset when no frame is sent) a low
    // line yields a code-0 report every PERIOD cycles.
    task automatic play(input string name, input int pre, input int trail,
                        input bit chk_lat, input bit chk_flat);
        int  n;
        int  prev_good;
        int  exp_code;
        int  exp_locked;
        int  ntz;
        int  total;
        int  base;
        int  k;
        int  rel_cyc;
        int  first_edge;
        int  trail_start;
        int  lat;

        // model
        exp_q.delete();
        n          = fr_hi.size();
        prev_good  = 0;
        exp_code   = 0;
        exp_locked = 0;
        ntz        = 0;
        for (int i = 0; i < n - 1; i++) begin
            if (fr_hi[i] + fr_lo[i] == PERIOD) begin
`ifdef PWM_CAPTURE_MATCH_EN
                if (fr_hi[i] == prev_good) begin
                    exp_q.push_back({1'b0, fr_hi[i][WIDTH-1:0]});
                    exp_code = fr_hi[i];
                end
                prev_good = fr_hi[i];
`else
                exp_q.push_back({1'b0, fr_hi[i][WIDTH-1:0]});
                exp_code = fr_hi[i];
`endif
                exp_locked = 1;
            end else begin
                exp_q.push_back({1'b1, {WIDTH{1'b0}}});
                exp_locked = 0;
                prev_good  = 0;
            end
        end
        if (n == 0) begin
            total = pre;
            base  = 1;
        end else begin
            total = fr_hi[n-1] + fr_lo[n-1] + trail;
            base  = 0;
        end
        k = 1;
        while (PERIOD * k + base + 4 <= total) begin
            exp_q.push_back({1'b0, {WIDTH{1'b0}}});
            exp_code   = 0;
            exp_locked = 1;
            ntz++;
            k++;
        end

        // reset and reset-state checks
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;
        @(negedge clk);
        check({name, ":rst_code"},   int'(code),   0);
        check({name, ":rst_valid"},  int'(valid),  0);
        check({name, ":rst_locked"}, int'(locked), 0);
        check({name, ":rst_err"},    int'(err),    0);
        #1;
        obs_q.delete();
        obs_cyc.delete();

        // stimulus
        drive(1'b0, pre);
        first_edge = cyc + 1;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, fr_hi[i]);
            drive(1'b0, fr_lo[i]);
        end
        trail_start = cyc + 1;
        drive(1'b0, trail);
        @(negedge clk);
        #1;

        // compare
        check({name, ":events"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s:ev%0d", name, i), int'(obs_q[i]), int'(exp_q[i]));
        check({name, ":locked"}, int'(locked), exp_locked);
        check({name, ":code"},   int'(code),   exp_code);

        if (chk_lat) begin
            lat = 100000;
            for (int i = obs_q.size() - 1; i >= 0; i--)
                if (obs_q[i][WIDTH] == 1'b0) lat = obs_cyc[i] - first_edge;
            check_range({name, ":first_valid_lat"}, lat, 0, 2 * PERIOD + SYNC_STAGES + 2);
        end
        if (n > 0 && ntz > 0 && obs_q.size() == exp_q.size())
            check_range({name, ":zero_lat"}, obs_cyc[exp_q.size() - ntz] - trail_start,
                        0, 2 * PERIOD);
        if (chk_flat && obs_q.size() == exp_q.size() && obs_q.size() > 0) begin
            check_range({name, ":flat_entry"}, obs_cyc[0] - rel_cyc, PERIOD, PERIOD + 4);
            for (int i = 1; i < obs_cyc.size(); i++)
                check($sformatf("%s:spacing%0d", name, i), obs_cyc[i] - obs_cyc[i-1], PERIOD);
        end

        fr_hi.delete();
        fr_lo.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        int mid;

        repeat (3) @(posedge clk);

        // steady low line
        play("flat", 800, 0, 1'b0, 1'b1);

        // code 100
        add_frames(100, 156, 6);
        play("c100", $urandom_range(20, 50), 10, 1'b1, 1'b0);

        // code 1
        add_frames(1, 255, 4);
        play("c1", $urandom_range(20, 50), 10, 1'b1, 1'b0);

        // code 255 then line drops to constant low
        add_frames(255, 1, 4);
        play("c255_to0", $urandom_range(20, 50), 600, 1'b1, 1'b0);

        // mid-stream change 100 -> 200 with one irregular frame between
        mid = $urandom_range(101, 199);
        add_frames(100, 156, 3);
        add_frames(mid, PERIOD - mid, 1);
        add_frames(200, 56, 4);
        play("c100_200", $urandom_range(20, 50), 10, 1'b1, 1'b0);

        // random codes, each sent for two frames
        for (int i = 0; i < 6; i++) begin
            c = $urandom_range(1, PERIOD - 1);
            add_frames(c, PERIOD - c, 2);
        end
        play("rand", $urandom_range(20, 50), 10, 1'b1, 1'b0);

        // wrong period (200) then restored 256-cycle frames
        add_frames(100, 100, 5);
        add_frames(100, 156, 4);
        play("sq200", $urandom_range(20, 50), 10, 1'b0, 1'b0);

        // locked at 100, stop mid-frame in the low phase; next play resets there
        add_frames(100, 156, 4);
        add_frames(100, 50, 1);
        play("pre_rst", $urandom_range(20, 50), 0, 1'b1, 1'b0);
        add_frames(100, 156, 4);
        play("relock", 106, 10, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
